rr_encoder_arbiter: RTL and testbench

Four-requester round-robin arbiter that shares one downstream resource, typically the 4-to-2 priority-encoded select path. It accepts a 4-bit request vector and issues a registered one-hot grant. It also provides the 2-bit binary index of the granted requester, the same encoding the encoder produces, so the shared datapath is steered directly. Grants are held until the owner releases its request. An optional hold-time limit prevents starvation.

---
 rtl/rr_encoder_arbiter_if.sv | 12 +
 rtl/rr_encoder_arbiter.sv | 135 +++++++++++++
 tb/tb_rr_encoder_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rr_encoder_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin encoder arbiter.
// The master side drives requests; the slave side returns the registered grant.
interface rr_encoder_arbiter_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] A;
   logic       valid;
   logic       timeout;

   modport master (output req, input gnt, A, valid, timeout);
   modport slave  (input req, output gnt, A, valid, timeout);
endinterface

// File: rtl/rr_encoder_arbiter.sv
// Four-requester round-robin arbiter with a registered one-hot grant and its binary index.
// Optional hold-time limit compiled in with ARB_TIMEOUT_EN (HOLD_MAX cycles per grant).
module rr_encoder_arbiter #(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rr_encoder_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_ptr;
   logic [1:0] r_owner;
   logic [3:0] r_gnt;
   logic [1:0] r_a;
   logic       r_valid;
   logic       r_timeout;

   logic [1:0] w_pick;
   logic       w_force;
   logic [1:0] w_ptr_nxt;
   logic [1:0] w_owner_nxt;
   logic [3:0] w_gnt_nxt;
   logic [1:0] w_a_nxt;
   logic       w_valid_nxt;
   logic       w_timeout_nxt;

   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
      $error("HOLD_MAX must be in 1..255");
   end

   // Rotating priority: scan downward so the requester closest to r_ptr wins.
   always_comb begin
      w_pick = r_ptr;
      for (int k = 3; k >= 0; k--) begin
         if (bus.req[r_ptr + 2'(k)]) w_pick = r_ptr + 2'(k);
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
   logic [7:0] r_hold;

   // Counter saturates at the limit so a late competitor is served immediately.
   always_ff @(posedge clk) begin
      if (!rst_n)                    r_hold <= '0;
      else if (r_state != S_GRANT)   r_hold <= '0;
      else if (r_hold != HOLD_LAST)  r_hold <= r_hold + 8'd1;
   end

   assign w_force = (r_hold == HOLD_LAST) && |(bus.req & ~r_gnt);
`else
   assign w_force = 1'b0;
`endif

   // NOTE: every flop below is written with <= so all state updates see the same pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ptr     <= 2'd0;
         r_owner   <= 2'd0;
         r_gnt     <= 4'd0;
         r_a       <= 2'd0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_owner   <= w_owner_nxt;
         r_gnt     <= w_gnt_nxt;
         r_a       <= w_a_nxt;
         r_valid   <= w_valid_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   // NOTE: defaults at the top of each always_comb keep every path assigned, so no latches appear.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:    if (|bus.req) w_state_nxt = S_GRANT;
         S_GRANT:   if (!bus.req[r_owner] || w_force) w_state_nxt = S_RELEASE;
         S_RELEASE: w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_ptr_nxt     = r_ptr;
      w_owner_nxt   = r_owner;
      w_gnt_nxt     = r_gnt;
      w_a_nxt       = r_a;
      w_valid_nxt   = r_valid;
      w_timeout_nxt = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (|bus.req) begin
               w_gnt_nxt   = 4'b0001 << w_pick;
               w_a_nxt     = w_pick;
               w_valid_nxt = 1'b1;
               w_owner_nxt = w_pick;
            end else begin
               w_gnt_nxt   = 4'd0;
               w_valid_nxt = 1'b0;
            end
         end
         S_GRANT: begin
            if (w_state_nxt == S_RELEASE) begin
               w_gnt_nxt     = 4'd0;
               w_valid_nxt   = 1'b0;
               w_ptr_nxt     = r_owner + 2'd1;
               // A voluntary drop takes precedence; only a still-requesting owner is forced out.
               w_timeout_nxt = bus.req[r_owner];
            end
         end
         S_RELEASE: begin
            w_gnt_nxt   = 4'd0;
            w_valid_nxt = 1'b0;
         end
         default: begin
            w_gnt_nxt   = 4'd0;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   assign bus.gnt     = r_gnt;
   assign bus.A       = r_a;
   assign bus.valid   = r_valid;
   assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Scoreboard bench for rr_encoder_arbiter: stimulus queues expected grants,
// a negedge monitor pops and checks each grant's owner, index, length and release pulse.
module tb_rr_encoder_arbiter;

`ifdef ARB_TIMEOUT_EN
   localparam int HOLD = 4;
`else
   localparam int HOLD = 15;
`endif

   logic clk;
   logic rst_n;
   logic mon_on;
   int   n_cmp;
   int   n_fail;

   rr_encoder_arbiter_if bus ();

   rr_encoder_arbiter #(.HOLD_MAX(HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] a;
      int         len;   // expected grant length in cycles, -1 when ended by reset
      logic       to;    // expected timeout pulse in the first cycle after the grant
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [3:0] g, input logic [1:0] a, input int len, input logic to);
      exp_t e;
      e.gnt = g;
      e.a   = a;
      e.len = len;
      e.to  = to;
      sb.push_back(e);
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] enc(input logic [3:0] g);
      case (g)
         4'b0010: enc = 2'd1;
         4'b0100: enc = 2'd2;
         4'b1000: enc = 2'd3;
         default: enc = 2'd0;
      endcase
   endfunction

   // Monitor: decoupled from stimulus, reacts only to what the DUT presents.
   initial begin
      logic       prev_valid;
      logic [3:0] prev_gnt;
      logic       have_cur;
      int         run;
      exp_t       cur;
      prev_valid = 1'b0;
      prev_gnt   = 4'd0;
      have_cur   = 1'b0;
      run        = 0;
      cur        = '{gnt: 4'd0, a: 2'd0, len: 0, to: 1'b0};
      forever begin
         @(negedge clk);
         if (mon_on) begin
            if (bus.valid) begin
               check("gnt_onehot", $countones(bus.gnt), 1);
               check("a_encodes_gnt", bus.A, enc(bus.gnt));
            end else begin
               check("gnt_zero_when_invalid", bus.gnt, 4'd0);
            end
            if (bus.valid && !prev_valid) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_grant: got gnt=%b, expected no grant (t=%0t)", bus.gnt, $time);
                  have_cur = 1'b0;
               end else begin
                  cur      = sb.pop_front();
                  have_cur = 1'b1;
                  check("grant_gnt", bus.gnt, cur.gnt);
                  check("grant_a", bus.A, cur.a);
               end
               run = 1;
               check("no_timeout_during_grant", bus.timeout, 1'b0);
            end else if (bus.valid && prev_valid) begin
               run++;
               check("gnt_stable", bus.gnt, prev_gnt);
               check("no_timeout_during_grant", bus.timeout, 1'b0);
            end else if (!bus.valid && prev_valid) begin
               if (have_cur) begin
                  if (cur.len >= 0) check("grant_length", run, cur.len);
                  check("timeout_at_release", bus.timeout, cur.to);
               end
               have_cur = 1'b0;
            end else begin
               check("no_stray_timeout", bus.timeout, 1'b0);
            end
            prev_valid = bus.valid;
            prev_gnt   = bus.gnt;
         end
      end
   end

   initial begin
      logic [3:0] drop;
      n_cmp   = 0;
      n_fail  = 0;
      mon_on  = 1'b0;
      rst_n   = 1'b0;
      bus.req = 4'd0;

      // Reset state
      hold(3);
      check("reset_gnt", bus.gnt, 4'd0);
      check("reset_a", bus.A, 2'd0);
      check("reset_valid", bus.valid, 1'b0);
      check("reset_timeout", bus.timeout, 1'b0);
      rst_n  = 1'b1;
      mon_on = 1'b1;

      // Single request; release leaves ptr at 3
      bus.req = 4'b0100;
      push(4'b0100, 2'd2, 3, 1'b0);
      hold(3);
      bus.req = 4'b0000;
      hold(3);

      // Pointer at 3 picks requester 3, then wraps to 0 while 3 is still requesting
      bus.req = 4'b1001;
      push(4'b1000, 2'd3, 2, 1'b0);
      hold(2);
      bus.req = 4'b0001;
      hold(1);
      bus.req = 4'b1001;
      push(4'b0001, 2'd0, 2, 1'b0);
      hold(3);
      bus.req = 4'b1000;
      push(4'b1000, 2'd3, 1, 1'b0);
      hold(3);
      bus.req = 4'b0000;
      hold(3);

      // Reset returns ptr to 0
      rst_n = 1'b0;
      hold(1);
      check("reset2_gnt", bus.gnt, 4'd0);
      check("reset2_valid", bus.valid, 1'b0);
      rst_n = 1'b1;

      // Fairness: all four request, each owner drops for one cycle after 3 grant cycles
      for (int i = 0; i < 5; i++) begin
         drop = 4'b0001 << (i % 4);
         push(drop, 2'(i % 4), 3, 1'b0);
      end
      bus.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         hold(3);
         if (i < 4) begin
            bus.req = 4'b1111 & ~(4'b0001 << i);
            hold(1);
            bus.req = 4'b1111;
            hold(1);
         end else begin
            bus.req = 4'b0000;
            hold(3);
         end
      end

`ifdef ARB_TIMEOUT_EN
      rst_n = 1'b0;
      hold(1);
      rst_n = 1'b1;

      // Contention with HOLD_MAX = 4: each owner forced out after 4 cycles
      bus.req = 4'b0011;
      push(4'b0001, 2'd0, 4, 1'b1);
      push(4'b0010, 2'd1, 4, 1'b1);
      hold(12);
      bus.req = 4'b0000;
      hold(3);

      // No contention: grant runs past the limit without a timeout
      bus.req = 4'b0001;
      push(4'b0001, 2'd0, 10, 1'b0);
      hold(10);
      bus.req = 4'b0000;
      hold(3);
`else
      // Long hold with others pending, then reset mid-grant
      bus.req = 4'b0111;
      push(4'b0010, 2'd1, -1, 1'b0);
      hold(20);
      check("long_hold_gnt", bus.gnt, 4'b0010);
      check("long_hold_a", bus.A, 2'd1);
      rst_n = 1'b0;
      hold(1);
      check("midgrant_reset_gnt", bus.gnt, 4'd0);
      check("midgrant_reset_a", bus.A, 2'd0);
      check("midgrant_reset_valid", bus.valid, 1'b0);
      rst_n = 1'b1;
      push(4'b0001, 2'd0, 2, 1'b0);
      hold(2);
      bus.req = 4'b0000;
      hold(3);
`endif

      hold(5);
      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
